// File: rtl/onehot_scan_encoder.sv
// Registered request-vector encoder: accepts an N-bit vector and streams the
// binary index of every set bit, one per valid/ready beat, in a fixed order.
module onehot_scan_encoder #(
  parameter int N         = 10,
  parameter int LSB_FIRST = 1,
  localparam int W        = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         out_multi,
  output logic         out_none
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t         state_reg;
  logic [N-1:0]   mask_reg;
  logic           multi_reg;
  logic           none_reg;
  logic [W-1:0]   pick;
  logic           single;

  // Later assignments win, so the scan runs toward the bit that must be emitted first.
  always_comb begin
    pick = '0;
    if (LSB_FIRST != 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (mask_reg[i]) pick = W'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (mask_reg[i]) pick = W'(i);
      end
    end
  end

  assign single    = (mask_reg != '0) && ((mask_reg & (mask_reg - N'(1))) == '0);
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == SCAN);
  assign out_idx   = pick;
  assign out_last  = out_valid & (single | none_reg);
  assign out_multi = multi_reg;
  assign out_none  = none_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      mask_reg  <= '0;
      multi_reg <= 1'b0;
      none_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            mask_reg  <= in_vec;
            multi_reg <= ((in_vec & (in_vec - N'(1))) != '0);
            none_reg  <= (in_vec == '0);
            state_reg <= SCAN;
          end
        end
        SCAN: begin
          if (out_ready) begin
            mask_reg <= mask_reg & ~(N'(1) << pick);
            if (out_last) begin
              state_reg <= IDLE;
              multi_reg <= 1'b0;
              none_reg  <= 1'b0;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_scan_encoder.sv
// Bench for onehot_scan_encoder: one ascending and one descending instance,
// each checked beat by beat against a queue of expected indices.
module tb_onehot_scan_encoder;

  logic       clk = 1'b0;
  logic [1:0] rst;
  logic [1:0] in_valid;
  logic [1:0] in_ready;
  logic [9:0] in_vec [2];
  logic [1:0] out_valid;
  logic [1:0] out_ready;
  logic [3:0] out_idx [2];
  logic [1:0] out_last;
  logic [1:0] out_multi;
  logic [1:0] out_none;

  int checks   = 0;
  int failures = 0;
  int pat [6]  = '{1, 0, 0, 1, 0, 1};

  always #5 clk = ~clk;

  onehot_scan_encoder #(.N(10), .LSB_FIRST(1)) dut_asc (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_vec(in_vec[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_idx(out_idx[0]), .out_last(out_last[0]), .out_multi(out_multi[0]),
    .out_none(out_none[0])
  );

  onehot_scan_encoder #(.N(10), .LSB_FIRST(0)) dut_desc (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_vec(in_vec[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_idx(out_idx[1]), .out_last(out_last[1]), .out_multi(out_multi[1]),
    .out_none(out_none[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Caller is positioned at a negedge with unit u idle. mode 0: out_ready
  // always 1, 1: random, 2: fixed toggle pattern.
  task automatic run_vec(input int u, input logic [9:0] v, input int mode);
    int  q[$];
    int  k;
    bit  multi;
    bit  none;
    int  low_cycles;
    int  cyc;
    bit  rdy;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) begin
        if (u == 0) q.push_back(i);
        else        q.push_front(i);
      end
    end
    k     = q.size();
    none  = (k == 0);
    multi = (k > 1);
    if (none) q.push_back(0);

    chk("in_ready_before_accept", in_ready[u], 1);
    in_valid[u] = 1'b1;
    in_vec[u]   = v;
    @(negedge clk);
    in_vec[u] = 10'($urandom);   // held valid during the scan must be ignored
    chk("first_beat_latency", out_valid[u], 1);

    low_cycles = 0;
    cyc        = 0;
    while (q.size() > 0 && cyc < 200) begin
      if (in_ready[u] == 1'b0) low_cycles++;
      chk("beat_valid", out_valid[u], 1);
      chk("beat_idx",   out_idx[u],   q[0]);
      chk("beat_last",  out_last[u],  (q.size() == 1));
      chk("beat_multi", out_multi[u], multi);
      chk("beat_none",  out_none[u],  none);
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = ($urandom_range(0, 1) == 1);
      else                rdy = (cyc < 6) ? (pat[cyc] != 0) : 1'b1;
      out_ready[u] = rdy;
      @(negedge clk);
      if (rdy) void'(q.pop_front());
      cyc++;
    end
    chk("scan_completed", q.size(), 0);
    in_valid[u]  = 1'b0;
    out_ready[u] = 1'b0;
    chk("idle_out_valid", out_valid[u], 0);
    chk("idle_in_ready",  in_ready[u],  1);
    if (mode == 0) chk("in_ready_low_cycles", low_cycles, (k == 0) ? 1 : k);
    $display("vec unit=%0d in=%b beats=%0d cycles=%0d", u, v, (k == 0) ? 1 : k, cyc);
  endtask

  initial begin
    rst       = 2'b11;
    in_valid  = 2'b00;
    out_ready = 2'b00;
    in_vec[0] = '0;
    in_vec[1] = '0;
    repeat (2) @(negedge clk);
    rst = 2'b00;
    for (int u = 0; u < 2; u++) begin
      chk("reset_in_ready",  in_ready[u],  1);
      chk("reset_out_valid", out_valid[u], 0);
      chk("reset_out_idx",   out_idx[u],   0);
      chk("reset_out_last",  out_last[u],  0);
      chk("reset_out_multi", out_multi[u], 0);
      chk("reset_out_none",  out_none[u],  0);
    end

    for (int i = 0; i < 10; i++) run_vec(0, 10'd1 << i, 0);
    run_vec(0, 10'b1000100101, 0);
    run_vec(1, 10'b1000100101, 0);
    run_vec(0, 10'b0000000000, 0);
    run_vec(1, 10'b0000000000, 0);
    run_vec(0, 10'b0000011010, 2);
    run_vec(1, 10'b0000011010, 2);
    run_vec(1, 10'b1000000000, 0);

    // Reset in the middle of a scan, while the second beat is on the bus.
    chk("rst_in_ready", in_ready[0], 1);
    in_valid[0]  = 1'b1;
    in_vec[0]    = 10'b1000100101;
    out_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    chk("rst_beat1_idx", out_idx[0], 0);
    @(negedge clk);
    chk("rst_beat2_idx", out_idx[0], 2);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0]       = 1'b0;
    out_ready[0] = 1'b0;
    chk("rst_abort_out_valid", out_valid[0], 0);
    chk("rst_abort_in_ready",  in_ready[0],  1);
    chk("rst_abort_out_multi", out_multi[0], 0);
    run_vec(0, 10'b0001000000, 0);

    for (int n = 0; n < 40; n++) begin
      run_vec(n % 2, 10'($urandom), $urandom_range(0, 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
